bit_scan_emitter: RTL and testbench
===================================

Name: bit_scan_emitter

Overview:
- Sequential counterpart to the ALU's bitwise OR path, working in the opposite direction. OR merges individual bits into a 32-bit word; this block splits a 32-bit word back into the indices of its set bits.
- Emits one index per cycle over a valid/ready stream.
- Sits beside the ALU. Used by multi-register save/restore (register-list masks) and by interrupt-pending dispatch.

Parameters:
- WIDTH, 32, width of the input word.
- IDXW, 5, index width; equals log2(WIDTH).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  input word is presented.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  word to decompose.
- out_valid  output  1  out_index/out_last/out_none are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_index  output  IDXW  bit position of the current set bit.
- out_last  output  1  current beat is the final beat for this word.
- out_none  output  1  input word was all zeros; index is meaningless.

Behaviour:
- Reset (reset==0, asynchronous) forces:
  - state=IDLE, mask register=0, zero-flag=0.
  - in_ready=1, out_valid=0, out_index=0, out_last=0, out_none=0.
  - Applies immediately, mid-scan included. A partially emitted word is discarded with no further beats.
- IDLE state:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at edge N: mask<=in_data, zero-flag<=(in_data==0), state<=SCAN.
- SCAN state:
  - in_ready=0, out_valid=1.
  - out_index = position of the lowest set bit of mask (priority encode, LSB first).
  - Zero-flag set: out_none=1, out_index=0, out_last=1.
  - out_last=1 when mask with the current bit cleared is zero.
  - On out_valid&&out_ready: clear the emitted bit in mask. If out_last, state<=IDLE.
  - With out_valid high and out_ready low: out_index, out_last and out_none hold stable; mask is unchanged.
- Latency and throughput:
  - First beat valid in the cycle after the accept edge N.
  - Steady state is one beat per cycle while out_ready=1.
  - A word with k set bits (k>=1) takes k beats; a zero word takes exactly 1 beat.
  - After the last handshake, in_ready=1 in the next cycle, so there is one bubble cycle between words. No input is accepted in the same cycle as the last output beat.
- out_index, out_last and out_none are decoded combinationally from registered state only. There is no combinational path from in_* to out_*.
- out_ready is ignored in IDLE; in_valid is ignored in SCAN.
- Mask bits above WIDTH-1 do not exist. With the default parameters, index 31 is the highest possible value and there is no wrap-around.

Optional Feature:
- Macro: BIT_SCAN_MSB_FIRST_EN.
- Defined: the priority encoder selects the highest set bit, so indices come out in descending order. out_last semantics are unchanged.
- Undefined (default): indices come out in ascending order (LSB first).
- All other timing, handshake and zero-word behaviour is identical in both builds.

Test Plan:
- in_data=0x0000_0005, out_ready=1:
  - beat 1: idx=0, last=0.
  - beat 2: idx=2, last=1.
  - in_ready=1 in the cycle after beat 2; exactly 2 beats total.
- in_data=0x0000_0000: exactly one beat, out_none=1, out_index=0, out_last=1, then in_ready=1.
- in_data=0x8000_0001 with out_ready=0 for 3 cycles:
  - out_valid=1 and idx=0 held stable for those 3 cycles.
  - Then idx=0 (last=0), idx=31 (last=1) on consecutive cycles.
- in_data=0xFFFF_FFFF, out_ready=1:
  - 32 beats on consecutive cycles, idx 0..31.
  - last=1 only on idx=31; in_valid held high is not accepted until IDLE.
- in_data=0x0000_00F0, reset driven to 0 after beats idx=4 and idx=5:
  - out_valid=0 and in_ready=1 asynchronously.
  - After release, in_data=0x2 produces one beat: idx=1, last=1.
- Build with BIT_SCAN_MSB_FIRST_EN, in_data=0x0000_0005: idx=2 (last=0), then idx=0 (last=1).

Source files
------------

// File: rtl/bit_scan_emitter.sv
// Splits a word into the indices of its set bits, one index per beat.
// Optional BIT_SCAN_MSB_FIRST_EN emits indices highest-first.
module bit_scan_emitter #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_index,
    output logic             out_last,
    output logic             out_none
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mask;
    logic             zero_flag;
    logic [IDXW-1:0]  pick;
    logic [WIDTH-1:0] pick_bit;
    logic             rest_zero;
    logic             scan;

    // Priority encoder; the final matching iteration wins.
    always_comb begin
        pick = '0;
`ifdef BIT_SCAN_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (mask[i]) pick = IDXW'(i);
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) pick = IDXW'(i);
        end
`endif
    end

    assign pick_bit  = {{(WIDTH-1){1'b0}}, 1'b1} << pick;
    assign rest_zero = (mask & ~pick_bit) == '0;
    assign scan      = (state == SCAN);

    assign out_index = (scan && !zero_flag) ? pick : '0;
    assign out_last  = scan && (zero_flag || rest_zero);
    assign out_none  = scan && zero_flag;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mask      <= '0;
            zero_flag <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mask      <= in_data;
                        zero_flag <= (in_data == '0);
                        state     <= SCAN;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        mask <= mask & ~pick_bit;
                        if (out_last) begin
                            state     <= IDLE;
                            zero_flag <= 1'b0;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_scan_emitter.sv
// Randomized bench for bit_scan_emitter against a queue-based index model.
// Define BIT_SCAN_MSB_FIRST_EN for both files to check the descending build.
module tb_bit_scan_emitter;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic        out_last;
    logic        out_none;

    int checks;
    int errors;

    bit_scan_emitter #(.WIDTH(32), .IDXW(5)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .out_none  (out_none)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the expected index sequence is just the set-bit positions.
    task automatic build_expect(input logic [31:0] d, output int q[$]);
        q = {};
        for (int i = 0; i < 32; i++) begin
            if (d[i]) begin
`ifdef BIT_SCAN_MSB_FIRST_EN
                q.push_front(i);
`else
                q.push_back(i);
`endif
            end
        end
        if (d == 0) q.push_back(0);
    endtask

    // Called at a negedge with the block idle.
    task automatic send_word(input logic [31:0] d, input int stall_pct,
                             input int hold_first, input bit keep_valid,
                             input int stop_after);
        int q[$];
        int total;
        int beats;
        int cyc;
        bit r;
        build_expect(d, q);
        total = q.size();
        beats = 0;
        cyc   = 0;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clock);
        if (!keep_valid) in_valid = 1'b0;
        while (q.size() > 0 && cyc < 300 && beats < stop_after) begin
            if (keep_valid) in_data = $urandom;
            check("scan_out_valid", out_valid, 1);
            check("scan_in_ready", in_ready, 0);
            check("out_index", out_index, q[0]);
            check("out_last", out_last, (q.size() == 1));
            check("out_none", out_none, (d == 0));
            if (cyc < hold_first) r = 1'b0;
            else r = ($urandom_range(99) >= stall_pct);
            out_ready = r;
            @(negedge clock);
            if (r) begin
                void'(q.pop_front());
                beats++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (stop_after >= total) begin
            check("beat_count", beats, total);
            check("done_in_ready", in_ready, 1);
            check("done_out_valid", out_valid, 0);
        end
    endtask

    initial begin
        logic [31:0] d;
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_none", out_none, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        send_word(32'h0000_0005, 0, 0, 0, 99);
        send_word(32'h0000_0000, 0, 0, 0, 99);
        send_word(32'h8000_0001, 0, 3, 0, 99);
        send_word(32'hFFFF_FFFF, 0, 0, 1, 99);

        // Abort mid-scan with an asynchronous reset.
        send_word(32'h0000_00F0, 0, 0, 0, 2);
        #2 reset = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_out_last", out_last, 0);
        check("arst_out_index", out_index, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        send_word(32'h0000_0002, 0, 0, 0, 99);

        for (int n = 0; n < 40; n++) begin
            unique case (n % 4)
                0: d = $urandom;
                1: d = $urandom & $urandom & $urandom;
                2: d = 32'h1 << $urandom_range(31);
                default: d = (n % 8 == 3) ? 32'h0 : ~($urandom & $urandom);
            endcase
            send_word(d, 30, 0, n[0], 99);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
